// File: rtl/ir_pkg.sv
// ir_pkg: key index type, key index constants and the IR scancode-to-key map
//   key_idx_t      5-bit key index
//   KEY_*          named key indices, KEY_UNKNOWN = 31 for unmapped codes
//   map_scancode   8-bit scancode -> key_idx_t
package ir_pkg;
    typedef logic [4:0] key_idx_t;
    localparam key_idx_t KEY_0       = 5'd0;
    localparam key_idx_t KEY_1       = 5'd1;
    localparam key_idx_t KEY_2       = 5'd2;
    localparam key_idx_t KEY_3       = 5'd3;
    localparam key_idx_t KEY_4       = 5'd4;
    localparam key_idx_t KEY_5       = 5'd5;
    localparam key_idx_t KEY_6       = 5'd6;
    localparam key_idx_t KEY_7       = 5'd7;
    localparam key_idx_t KEY_8       = 5'd8;
    localparam key_idx_t KEY_9       = 5'd9;
    localparam key_idx_t KEY_CHM     = 5'd10;
    localparam key_idx_t KEY_CH      = 5'd11;
    localparam key_idx_t KEY_CHP     = 5'd12;
    localparam key_idx_t KEY_PREV    = 5'd13;
    localparam key_idx_t KEY_NEXT    = 5'd14;
    localparam key_idx_t KEY_PLAY    = 5'd15;
    localparam key_idx_t KEY_VOLM    = 5'd16;
    localparam key_idx_t KEY_VOLP    = 5'd17;
    localparam key_idx_t KEY_EQ      = 5'd18;
    localparam key_idx_t KEY_100P    = 5'd19;
    localparam key_idx_t KEY_200P    = 5'd20;
    localparam key_idx_t KEY_UNKNOWN = 5'd31;

    function automatic key_idx_t map_scancode(input logic [7:0] code);
        case (code)
            8'h16:   map_scancode = KEY_0;
            8'h0C:   map_scancode = KEY_1;
            8'h18:   map_scancode = KEY_2;
            8'h5E:   map_scancode = KEY_3;
            8'h08:   map_scancode = KEY_4;
            8'h1C:   map_scancode = KEY_5;
            8'h5A:   map_scancode = KEY_6;
            8'h42:   map_scancode = KEY_7;
            8'h52:   map_scancode = KEY_8;
            8'h4A:   map_scancode = KEY_9;
            8'h45:   map_scancode = KEY_CHM;
            8'h46:   map_scancode = KEY_CH;
            8'h47:   map_scancode = KEY_CHP;
            8'h44:   map_scancode = KEY_PREV;
            8'h40:   map_scancode = KEY_NEXT;
            8'h43:   map_scancode = KEY_PLAY;
            8'h07:   map_scancode = KEY_VOLM;
            8'h15:   map_scancode = KEY_VOLP;
            8'h09:   map_scancode = KEY_EQ;
            8'h19:   map_scancode = KEY_100P;
            8'h0D:   map_scancode = KEY_200P;
            default: map_scancode = KEY_UNKNOWN;
        endcase
    endfunction
endpackage

// File: rtl/ir_keymap.sv
// ir_keymap: combinational keymap ROM
//   code  in  8  scancode
//   idx   out 5  key index (KEY_UNKNOWN when unmapped)
module ir_keymap
    import ir_pkg::*;
(
    input  logic [7:0] code,
    output key_idx_t   idx
);
    assign idx = map_scancode(code);
endmodule

// File: rtl/ir_key_queue.sv
// ir_key_queue: detects new IR scancodes, maps them to key indices and queues them in a FWFT FIFO
//   clk, reset  clock, asynchronous active-high reset
//   code_in     held-level scancode, 8'h00 = no key
//   key_valid/key_ready/key_idx/key_raw  head entry pop interface
//   level       number of queued entries
//   overflow    sticky drop flag, cleared by ovf_clr (a new drop wins)
module ir_key_queue
    import ir_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter bit DROP_UNKNOWN = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [7:0]               code_in,
    output logic                     key_valid,
    input  logic                     key_ready,
    output key_idx_t                 key_idx,
    output logic [7:0]               key_raw,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    input  logic                     ovf_clr
);
    localparam int AW = $clog2(DEPTH);
    logic [7:0]  last_code;
    key_idx_t    idx;
    logic [AW:0] wr_cnt, rd_cnt;
    logic [12:0] mem [DEPTH];
    logic        new_evt, push, pop, full, wr_en;

    ir_keymap u_keymap (.code(code_in), .idx(idx));

    assign new_evt   = (code_in != last_code) && (code_in != 8'h00);
    assign push      = new_evt && !(DROP_UNKNOWN && idx == KEY_UNKNOWN);
    assign level     = wr_cnt - rd_cnt;
    assign key_valid = level != '0;
    assign full      = level == (AW+1)'(DEPTH);
    assign pop       = key_valid && key_ready;
    // a full FIFO still accepts a push when the head leaves on the same edge
    assign wr_en     = push && (!full || pop);
    assign {key_idx, key_raw} = key_valid ? mem[rd_cnt[AW-1:0]] : 13'd0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_code <= 8'h00;
            wr_cnt    <= '0;
            rd_cnt    <= '0;
            overflow  <= 1'b0;
        end else begin
            if (code_in != last_code) last_code <= code_in;
            if (wr_en) wr_cnt <= wr_cnt + (AW+1)'(1);
            if (pop) rd_cnt <= rd_cnt + (AW+1)'(1);
            overflow <= (push && !wr_en) || (overflow && !ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_cnt[AW-1:0]] <= {idx, code_in};
    end
endmodule

// File: tb/tb_ir_key_queue.sv
module tb_ir_key_queue;
    logic clk = 1'b0, reset = 1'b1, key_ready = 1'b0, ovf_clr = 1'b0;
    logic [7:0] code_in = 8'h00;
    logic       kv  [2];
    logic [4:0] kix [2];
    logic [7:0] kraw[2];
    logic [2:0] lvl [2];
    logic       ovf [2];
    int tests = 0, fails = 0;

    always #10 clk = ~clk;

    ir_key_queue #(.DEPTH(4), .DROP_UNKNOWN(1'b1)) dut_drop (
        .clk(clk), .reset(reset), .code_in(code_in), .key_valid(kv[0]), .key_ready(key_ready),
        .key_idx(kix[0]), .key_raw(kraw[0]), .level(lvl[0]), .overflow(ovf[0]), .ovf_clr(ovf_clr));
    ir_key_queue #(.DEPTH(4), .DROP_UNKNOWN(1'b0)) dut_keep (
        .clk(clk), .reset(reset), .code_in(code_in), .key_valid(kv[1]), .key_ready(key_ready),
        .key_idx(kix[1]), .key_raw(kraw[1]), .level(lvl[1]), .overflow(ovf[1]), .ovf_clr(ovf_clr));

    // Reference model: keymap as a lookup list, FIFO as an unbounded ring with a DEPTH limit
    logic [7:0] keymap [21] = '{8'h16, 8'h0C, 8'h18, 8'h5E, 8'h08, 8'h1C, 8'h5A, 8'h42, 8'h52, 8'h4A,
                                8'h45, 8'h46, 8'h47, 8'h44, 8'h40, 8'h43, 8'h07, 8'h15, 8'h09, 8'h19, 8'h0D};
    logic [12:0] mbuf [2][64];
    int          mhead [2], mcnt [2];
    logic        movf [2];
    logic [7:0]  mlast;

    function automatic logic [4:0] ref_map(input logic [7:0] c);
        for (int i = 0; i < 21; i++) if (keymap[i] == c) return 5'(i);
        return 5'd31;
    endfunction

    task automatic model_step();
        logic [4:0] id;
        bit nev, psh, pp, full;
        if (reset) begin
            for (int k = 0; k < 2; k++) begin
                mhead[k] = 0; mcnt[k] = 0; movf[k] = 1'b0;
            end
            mlast = 8'h00;
            return;
        end
        id  = ref_map(code_in);
        nev = code_in != mlast && code_in != 8'h00;
        for (int k = 0; k < 2; k++) begin
            psh  = nev && !(k == 0 && id == 5'd31);
            pp   = mcnt[k] > 0 && key_ready;
            full = mcnt[k] == 4;
            if (ovf_clr) movf[k] = 1'b0;
            if (pp) begin
                mhead[k] = (mhead[k] + 1) % 64; mcnt[k]--;
            end
            if (psh && full && !pp) movf[k] = 1'b1;
            else if (psh) begin
                mbuf[k][(mhead[k] + mcnt[k]) % 64] = {id, code_in}; mcnt[k]++;
            end
        end
        mlast = code_in;
    endtask

    always @(posedge clk or posedge reset) model_step();

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic [12:0] h;
        for (int k = 0; k < 2; k++) begin
            h = mcnt[k] > 0 ? mbuf[k][mhead[k]] : 13'd0;
            chk($sformatf("cyc%0d.valid", k), int'(kv[k]), int'(mcnt[k] > 0));
            chk($sformatf("cyc%0d.level", k), int'(lvl[k]), mcnt[k]);
            chk($sformatf("cyc%0d.ovf", k), int'(ovf[k]), int'(movf[k]));
            chk($sformatf("cyc%0d.idx", k), int'(kix[k]), int'(h[12:8]));
            chk($sformatf("cyc%0d.raw", k), int'(kraw[k]), int'(h[7:0]));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        tick(2);
        chk("reset.level", int'(lvl[0]), 0);
        chk("reset.ovf", int'(ovf[0]), 0);
        reset = 1'b0;
        tick(1);
        code_in = 8'h0C; tick(1);
        chk("t1.valid", int'(kv[0]), 1);
        chk("t1.idx", int'(kix[0]), 1);
        chk("t1.raw", int'(kraw[0]), 8'h0C);
        chk("t1.level", int'(lvl[0]), 1);
        key_ready = 1'b1; tick(1);
        chk("t1.popped", int'(kv[0]), 0);
        key_ready = 1'b0; code_in = 8'h00; tick(1);
        code_in = 8'h45; tick(100);
        chk("t2.held_level", int'(lvl[0]), 1);
        chk("t2.idx", int'(kix[0]), 10);
        code_in = 8'h00; tick(1);
        code_in = 8'h45; tick(1);
        chk("t2.repress_level", int'(lvl[0]), 2);
        key_ready = 1'b1; tick(2);
        key_ready = 1'b0; code_in = 8'h00; tick(1);
        code_in = 8'hAA; tick(1);
        chk("t3.drop_level", int'(lvl[0]), 0);
        chk("t3.keep_level", int'(lvl[1]), 1);
        chk("t3.keep_idx", int'(kix[1]), 31);
        chk("t3.keep_raw", int'(kraw[1]), 8'hAA);
        key_ready = 1'b1; tick(1);
        key_ready = 1'b0; code_in = 8'h00; tick(1);
        foreach (keymap[i]) if (i < 5) begin
            code_in = keymap[i]; tick(1);
        end
        chk("t4.level", int'(lvl[0]), 4);
        chk("t4.ovf", int'(ovf[0]), 1);
        key_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t4.pop%0d", i), int'(kix[0]), i);
            tick(1);
        end
        key_ready = 1'b0;
        chk("t4.empty", int'(lvl[0]), 0);
        ovf_clr = 1'b1; tick(1);
        ovf_clr = 1'b0;
        chk("t4.ovf_clr", int'(ovf[0]), 0);
        foreach (keymap[i]) if (i < 4) begin
            code_in = keymap[i]; tick(1);
        end
        chk("t5.full", int'(lvl[0]), 4);
        key_ready = 1'b1; code_in = 8'h1C; tick(1);
        chk("t5.level", int'(lvl[0]), 4);
        chk("t5.ovf", int'(ovf[0]), 0);
        tick(3);
        chk("t5.last_raw", int'(kraw[0]), 8'h1C);
        tick(1);
        key_ready = 1'b0;
        chk("t5.drained", int'(lvl[0]), 0);
        code_in = 8'h16; tick(1);
        code_in = 8'h0C; tick(1);
        code_in = 8'h43; tick(1);
        chk("t6.level", int'(lvl[0]), 3);
        reset = 1'b1; #1;
        chk("t6.reset_level", int'(lvl[0]), 0);
        tick(2);
        reset = 1'b0; tick(1);
        chk("t6.requeue_level", int'(lvl[0]), 1);
        chk("t6.requeue_idx", int'(kix[0]), 15);
        tick(2);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
